// File: rtl/gmii_phy_tx_nibble_if_pkg.sv
// Shared types for the GMII/MII transmit adapter: FSM states, mode encoding
// and the {txd, en, er} bundle that flows down the PHY output pipeline.
package gmii_phy_pkg;

    typedef enum logic [1:0] {IDLE, GMII, MII_LO, MII_HI} tx_state_t;

    localparam logic MODE_GMII = 1'b0;
    localparam logic MODE_MII  = 1'b1;

    localparam int BUNDLE_W = 10;

    typedef struct packed {
        logic [7:0] txd;
        logic       en;
        logic       er;
    } tx_bundle_t;

    localparam tx_bundle_t BUNDLE_IDLE = '0;

    // MII nibble on txd[3:0]; the upper pins are held low.
    function automatic tx_bundle_t nibble_bundle(input logic [3:0] nib, input logic err);
        return '{txd: {4'h0, nib}, en: 1'b1, er: err};
    endfunction

endpackage

// File: rtl/gmii_phy_tx_nibble_if_rst_sync.sv
// Reset synchroniser: asynchronous assert, release after STAGES rising edges.
module rst_sync #(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    output logic rst_out
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end

    assign rst_out = sync_q[STAGES-1];

endmodule

// File: rtl/gmii_phy_tx_nibble_if.sv
// TX PHY adapter: passes MAC bytes to GMII pins or serialises them to MII
// nibbles, switching modes only between frames, with a frame counter.
module gmii_phy_tx_nibble_if
    import gmii_phy_pkg::*;
#(
    parameter int RST_SYNC_STAGES = 4,
    parameter int OUT_PIPE        = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 mac_gmii_tx_clk,
    input  logic                 rst,
    input  logic                 mii_select,
    output logic                 mac_gmii_tx_rst,
    input  logic [7:0]           mac_txd,
    input  logic                 mac_tx_en,
    input  logic                 mac_tx_er,
    output logic                 mac_tx_ready,
    output logic [7:0]           phy_gmii_txd,
    output logic                 phy_gmii_tx_en,
    output logic                 phy_gmii_tx_er,
    output logic                 mode_mii,
    output logic [CNT_WIDTH-1:0] frame_count
);

    logic       sel_m;
    logic       sel_s;
    tx_state_t  state;
    tx_bundle_t emit_q;
    tx_bundle_t phy_q;
    logic [3:0] cap_hi;
    logic       cap_er;

    rst_sync #(.STAGES(RST_SYNC_STAGES)) u_rst_sync (
        .clk     (mac_gmii_tx_clk),
        .rst     (rst),
        .rst_out (mac_gmii_tx_rst)
    );

    always_ff @(posedge mac_gmii_tx_clk or posedge rst) begin
        if (rst) {sel_s, sel_m} <= 2'b00;
        else     {sel_s, sel_m} <= {sel_m, mii_select};
    end

    // The synchronised reset rises asynchronously with rst and falls on a
    // clock edge, so it gives both the async clear and the release hold.
    always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
        if (mac_gmii_tx_rst) begin
            state       <= IDLE;
            emit_q      <= BUNDLE_IDLE;
            cap_hi      <= 4'h0;
            cap_er      <= 1'b0;
            mode_mii    <= MODE_GMII;
            frame_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mac_tx_en) begin
                        frame_count <= frame_count + 1'b1;
                        if (mode_mii == MODE_MII) begin
                            emit_q <= nibble_bundle(mac_txd[3:0], mac_tx_er);
                            cap_hi <= mac_txd[7:4];
                            cap_er <= mac_tx_er;
                            state  <= MII_LO;
                        end else begin
                            emit_q <= '{txd: mac_txd, en: 1'b1, er: mac_tx_er};
                            state  <= GMII;
                        end
                    end else begin
                        emit_q   <= BUNDLE_IDLE;
                        mode_mii <= sel_s;
                    end
                end
                GMII: begin
                    if (mac_tx_en) begin
                        emit_q <= '{txd: mac_txd, en: 1'b1, er: mac_tx_er};
                    end else begin
                        emit_q <= BUNDLE_IDLE;
                        state  <= IDLE;
                    end
                end
                MII_LO: begin
                    emit_q <= nibble_bundle(cap_hi, cap_er);
                    state  <= MII_HI;
                end
                MII_HI: begin
                    if (mac_tx_en) begin
                        emit_q <= nibble_bundle(mac_txd[3:0], mac_tx_er);
                        cap_hi <= mac_txd[7:4];
                        cap_er <= mac_tx_er;
                        state  <= MII_LO;
                    end else begin
                        emit_q <= BUNDLE_IDLE;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mac_tx_ready = !mac_gmii_tx_rst && (state != MII_LO);

    // emit_q is the first output stage; extra stages are appended here.
    if (OUT_PIPE > 1) begin : g_pipe
        logic [BUNDLE_W-1:0] tail_q [OUT_PIPE-1];

        always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
            if (mac_gmii_tx_rst) begin
                for (int i = 0; i < OUT_PIPE-1; i++) tail_q[i] <= '0;
            end else begin
                tail_q[0] <= emit_q;
                for (int i = 1; i < OUT_PIPE-1; i++) tail_q[i] <= tail_q[i-1];
            end
        end

        assign phy_q = tx_bundle_t'(tail_q[OUT_PIPE-2]);
    end else begin : g_nopipe
        assign phy_q = emit_q;
    end

    assign phy_gmii_txd   = phy_q.txd;
    assign phy_gmii_tx_en = phy_q.en;
    assign phy_gmii_tx_er = phy_q.er;

endmodule

// File: tb/tb_gmii_phy_tx_nibble_if.sv
// Bench for gmii_phy_tx_nibble_if: two configurations driven in lockstep and
// checked each cycle against a time-stamped schedule of expected PHY output.
module tb_gmii_phy_tx_nibble_if;

    localparam int ST0 = 4, P0 = 1;
    localparam int ST1 = 2, P1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mii_select = 1'b0;
    logic [7:0] mac_txd = 8'h00;
    logic mac_tx_en = 1'b0;
    logic mac_tx_er = 1'b0;

    logic [1:0]      tx_rst_o, ready_o, en_o, er_o, mode_o;
    logic [1:0][7:0] txd_o;
    logic [15:0]     fc0;
    logic [1:0]      fc1;

    always #5 clk = ~clk;

    gmii_phy_tx_nibble_if #(.RST_SYNC_STAGES(ST0), .OUT_PIPE(P0), .CNT_WIDTH(16)) dut0 (
        .mac_gmii_tx_clk(clk), .rst(rst), .mii_select(mii_select),
        .mac_gmii_tx_rst(tx_rst_o[0]), .mac_txd(mac_txd), .mac_tx_en(mac_tx_en),
        .mac_tx_er(mac_tx_er), .mac_tx_ready(ready_o[0]), .phy_gmii_txd(txd_o[0]),
        .phy_gmii_tx_en(en_o[0]), .phy_gmii_tx_er(er_o[0]), .mode_mii(mode_o[0]),
        .frame_count(fc0)
    );

    gmii_phy_tx_nibble_if #(.RST_SYNC_STAGES(ST1), .OUT_PIPE(P1), .CNT_WIDTH(2)) dut1 (
        .mac_gmii_tx_clk(clk), .rst(rst), .mii_select(mii_select),
        .mac_gmii_tx_rst(tx_rst_o[1]), .mac_txd(mac_txd), .mac_tx_en(mac_tx_en),
        .mac_tx_er(mac_tx_er), .mac_tx_ready(ready_o[1]), .phy_gmii_txd(txd_o[1]),
        .phy_gmii_tx_en(en_o[1]), .phy_gmii_tx_er(er_o[1]), .mode_mii(mode_o[1]),
        .frame_count(fc1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pst(input int k);  return (k == 0) ? P0 : P1; endfunction
    function automatic int stg(input int k);  return (k == 0) ? ST0 : ST1; endfunction
    function automatic int cmask(input int k); return (k == 0) ? 32'hFFFF : 32'h3; endfunction

    // Behavioural model: each accepted byte schedules the PHY bundle(s) it must
    // produce at absolute cycle numbers; a frame fixes its mode at its start.
    int   cyc = 0;
    int   rel_cnt [2] = '{0, 0};
    bit   busy    [2] = '{0, 0};
    bit   half    [2] = '{0, 0};
    bit   mode_m  [2] = '{0, 0};
    bit   s1      [2] = '{0, 0};
    bit   s2      [2] = '{0, 0};
    int   cnt     [2] = '{0, 0};
    logic [9:0] ring [2][16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rel_cnt[k] = 0; busy[k] = 0; half[k] = 0; mode_m[k] = 0;
                s1[k] = 0; s2[k] = 0; cnt[k] = 0;
                for (int i = 0; i < 16; i++) ring[k][i] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int p;
                p = pst(k);
                if (rel_cnt[k] < stg(k)) begin
                    ring[k][(cyc+p)%16] = '0;
                end else if (half[k]) begin
                    half[k] = 0;
                end else if (!mac_tx_en) begin
                    if (!busy[k]) mode_m[k] = s2[k];
                    busy[k] = 0;
                    ring[k][(cyc+p)%16] = '0;
                end else begin
                    if (!busy[k]) begin
                        busy[k] = 1;
                        cnt[k] = (cnt[k] + 1) & cmask(k);
                    end
                    if (mode_m[k]) begin
                        ring[k][(cyc+p)%16]   = {4'h0, mac_txd[3:0], 1'b1, mac_tx_er};
                        ring[k][(cyc+p+1)%16] = {4'h0, mac_txd[7:4], 1'b1, mac_tx_er};
                        half[k] = 1;
                    end else begin
                        ring[k][(cyc+p)%16] = {mac_txd, 1'b1, mac_tx_er};
                    end
                end
                s2[k] = s1[k];
                s1[k] = mii_select;
                if (rel_cnt[k] < stg(k)) rel_cnt[k]++;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [9:0] e;
            logic       rdy;
            e   = ring[k][cyc%16];
            rdy = (rel_cnt[k] >= stg(k)) && !half[k];
            chk($sformatf("tx_rst%0d", k), tx_rst_o[k], (rel_cnt[k] < stg(k)) ? 1 : 0);
            chk($sformatf("ready%0d", k),  ready_o[k], rdy);
            chk($sformatf("txd%0d", k),    txd_o[k], e[9:2]);
            chk($sformatf("tx_en%0d", k),  en_o[k], e[1]);
            chk($sformatf("tx_er%0d", k),  er_o[k], e[0]);
            chk($sformatf("mode%0d", k),   mode_o[k], mode_m[k]);
            chk($sformatf("fcount%0d", k), (k == 0) ? 32'(fc0) : 32'(fc1), cnt[k]);
        end
    end

    // Output trace of the first instance, used by the literal checks.
    bit         rec_on = 0;
    logic [7:0] r_txd [$];
    bit         r_en  [$];
    bit         r_er  [$];
    bit         r_rdy [$];

    always @(negedge clk) begin
        if (rec_on) begin
            r_txd.push_back(txd_o[0]);
            r_en.push_back(en_o[0]);
            r_er.push_back(er_o[0]);
            r_rdy.push_back(ready_o[0]);
        end
    end

    task automatic rec_start();
        r_txd.delete(); r_en.delete(); r_er.delete(); r_rdy.delete();
        rec_on = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic en, input logic er);
        int guard;
        guard = 0;
        mac_txd = d; mac_tx_en = en; mac_tx_er = er;
        while (ready_o[0] !== 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        if (ready_o[0] !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: ready %b, required 1", ready_o[0]);
        end
        step();
    endtask

    task automatic send_idle();
        send(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulse_reset(input int hold);
        #1;
        rst = 1'b1;
        mac_tx_en = 1'b0;
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) step();
    endtask

    // Locate the first enabled output and compare the frame against literals.
    task automatic check_seq(input string nm, input logic [7:0] et[$], input bit ee[$]);
        int a;
        a = -1;
        for (int i = 0; i < r_en.size(); i++) if (r_en[i] && a < 0) a = i;
        if (a < 1 || a + et.size() >= r_en.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s_window: first tx_en at %0d of %0d samples", nm, a, r_en.size());
            return;
        end
        chk({nm, "_ready_at_accept"}, r_rdy[a-1], 1);
        for (int i = 0; i < et.size(); i++) begin
            chk({nm, "_txd"}, r_txd[a+i], et[i]);
            chk({nm, "_en"},  r_en[a+i], 1);
            chk({nm, "_er"},  r_er[a+i], ee[i]);
        end
        chk({nm, "_en_after"}, r_en[a+et.size()], 0);
        chk({nm, "_er_before"}, r_er[a-1], 0);
    endtask

    task automatic rand_frame();
        int len, rat;
        len = $urandom_range(1, 12);
        rat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len-1)) : -1;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 15) == 0) mii_select = ~mii_select;
            send(8'($urandom_range(0, 255)), 1'b1, ($urandom_range(0, 7) == 0));
            if (i == rat) begin
                pulse_reset($urandom_range(1, 3));
                return;
            end
        end
        repeat ($urandom_range(1, 3)) send_idle();
    endtask

    initial begin
        int fall0, fall1;
        bit rdy_at_fall;
        logic [7:0] et[$];
        bit ee[$];

        // Reset release
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        fall0 = 0; fall1 = 0; rdy_at_fall = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (!tx_rst_o[0] && fall0 == 0) begin fall0 = e; rdy_at_fall = ready_o[0]; end
            if (!tx_rst_o[1] && fall1 == 0) fall1 = e;
        end
        chk("rst_release_edges0", fall0, 4);
        chk("rst_release_edges1", fall1, 2);
        chk("ready_at_release", rdy_at_fall, 1);
        repeat (3) send_idle();

        // GMII frame
        rec_start();
        send(8'h55, 1, 0); send(8'h55, 1, 0); send(8'hD5, 1, 0); send(8'hA1, 1, 0);
        send_idle(); send_idle(); send_idle();
        rec_on = 0;
        et = '{8'h55, 8'h55, 8'hD5, 8'hA1};
        ee = '{0, 0, 0, 0};
        check_seq("gmii", et, ee);
        chk("gmii_fcount0", fc0, 1);
        chk("gmii_fcount1", fc1, 1);

        // Mode request arriving mid-frame is held off until the frame ends
        for (int i = 0; i < 64; i++) begin
            if (i == 20) mii_select = 1'b1;
            send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk("mode_held_in_frame", mode_o[0], 0);
        end
        send_idle();
        chk("mode_still_gmii_at_idle", mode_o[0], 0);
        send_idle();
        chk("mode_mii_after_idle", mode_o[0], 1);
        send_idle();

        // MII frame and ready cadence
        rec_start();
        send(8'hD5, 1, 0); send(8'h3C, 1, 0);
        send_idle(); send_idle(); send_idle();
        rec_on = 0;
        et = '{8'h05, 8'h0D, 8'h0C, 8'h03};
        ee = '{0, 0, 0, 0};
        check_seq("mii", et, ee);
        for (int i = 0; i < r_en.size(); i++) begin
            if (r_en[i] && i >= 1 && i + 2 < r_rdy.size()) begin
                chk("mii_ready_p0", r_rdy[i-1], 1);
                chk("mii_ready_p1", r_rdy[i],   0);
                chk("mii_ready_p2", r_rdy[i+1], 1);
                chk("mii_ready_p3", r_rdy[i+2], 0);
                break;
            end
        end

        // Error on a single MII byte covers both of its nibbles only
        rec_start();
        send(8'h11, 1, 0); send(8'h7E, 1, 1); send(8'h22, 1, 0);
        send_idle(); send_idle(); send_idle();
        rec_on = 0;
        et = '{8'h01, 8'h01, 8'h0E, 8'h07, 8'h02, 8'h02};
        ee = '{0, 0, 1, 1, 0, 0};
        check_seq("mii_err", et, ee);

        // Asynchronous reset while the low nibble is on the pins
        send(8'hAB, 1, 0);
        chk("in_mii_lo_ready", ready_o[0], 0);
        #1;
        rst = 1'b1;
        mac_tx_en = 1'b0;
        #1;
        chk("rst_async_en0",  en_o[0], 0);
        chk("rst_async_txd0", txd_o[0], 0);
        chk("rst_async_en1",  en_o[1], 0);
        chk("rst_async_txd1", txd_o[1], 0);
        chk("rst_async_fc0",  fc0, 0);
        chk("rst_async_fc1",  fc1, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) step();
        chk("mode_reload_after_rst", mode_o[0], 1);
        send(8'h5A, 1, 0); send(8'hC3, 1, 0); send_idle();
        chk("fc_after_rst0", fc0, 1);
        chk("fc_after_rst1", fc1, 1);
        for (int f = 0; f < 4; f++) begin
            send(8'($urandom_range(0, 255)), 1, 0);
            send_idle();
        end
        chk("fc_five0", fc0, 5);
        chk("fc_wrap1", fc1, 1);

        // Randomised traffic with mode flips and occasional resets
        for (int f = 0; f < 80; f++) rand_frame();
        repeat (4) send_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
